// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Contents: FSM state enum, LUT entry struct (element count + MSB-first
// dash/dot pattern), element/space constants and an ASCII case-fold helper.
package morse_pkg;

   localparam int unsigned MORSE_MAX_ELEMS = 6;
   localparam logic [7:0]  ASCII_SPACE     = 8'h20;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MARK   = 3'd1,
      ESPACE = 3'd2,
      LGAP   = 3'd3,
      WGAP   = 3'd4
   } morse_state_t;

   // pat is left-aligned: element 0 sits in pat[MORSE_MAX_ELEMS-1]; 1 = dash.
   typedef struct packed {
      logic [2:0]                 len;
      logic [MORSE_MAX_ELEMS-1:0] pat;
   } morse_entry_t;

   // Fold 'a'..'z' onto 'A'..'Z'; every other byte passes through.
   function automatic logic [7:0] fold_upper(input logic [7:0] c);
      logic [7:0] r;
      r = c;
      if (c >= 8'h61 && c <= 8'h7A) begin
         r = c - 8'h20;
      end
      return r;
   endfunction

endpackage

// File: rtl/morse_char_lut.sv
// ASCII to Morse element table (letters folded to upper case, digits, . , ? / = -).
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
//
// Ports: ascii   - input byte
//        entry   - element count and left-aligned pattern (1 = dash)
//        is_space- byte is 0x20 (word gap, no elements)
//        valid   - byte is supported (including space)
module morse_char_lut
   import morse_pkg::*;
(
   input  logic [7:0]   ascii,
   output morse_entry_t entry,
   output logic         is_space,
   output logic         valid
);

   logic [7:0] c;

   always_comb begin
      c        = fold_upper(ascii);
      entry    = '0;
      is_space = 1'b0;
      valid    = 1'b1;
      case (c)
         ASCII_SPACE: is_space = 1'b1;
         8'h41: entry = {3'd2, 6'b010000}; // A .-
         8'h42: entry = {3'd4, 6'b100000}; // B -...
         8'h43: entry = {3'd4, 6'b101000}; // C -.-.
         8'h44: entry = {3'd3, 6'b100000}; // D -..
         8'h45: entry = {3'd1, 6'b000000}; // E .
         8'h46: entry = {3'd4, 6'b001000}; // F ..-.
         8'h47: entry = {3'd3, 6'b110000}; // G --.
         8'h48: entry = {3'd4, 6'b000000}; // H ....
         8'h49: entry = {3'd2, 6'b000000}; // I ..
         8'h4A: entry = {3'd4, 6'b011100}; // J .---
         8'h4B: entry = {3'd3, 6'b101000}; // K -.-
         8'h4C: entry = {3'd4, 6'b010000}; // L .-..
         8'h4D: entry = {3'd2, 6'b110000}; // M --
         8'h4E: entry = {3'd2, 6'b100000}; // N -.
         8'h4F: entry = {3'd3, 6'b111000}; // O ---
         8'h50: entry = {3'd4, 6'b011000}; // P .--.
         8'h51: entry = {3'd4, 6'b110100}; // Q --.-
         8'h52: entry = {3'd3, 6'b010000}; // R .-.
         8'h53: entry = {3'd3, 6'b000000}; // S ...
         8'h54: entry = {3'd1, 6'b100000}; // T -
         8'h55: entry = {3'd3, 6'b001000}; // U ..-
         8'h56: entry = {3'd4, 6'b000100}; // V ...-
         8'h57: entry = {3'd3, 6'b011000}; // W .--
         8'h58: entry = {3'd4, 6'b100100}; // X -..-
         8'h59: entry = {3'd4, 6'b101100}; // Y -.--
         8'h5A: entry = {3'd4, 6'b110000}; // Z --..
         8'h30: entry = {3'd5, 6'b111110}; // 0 -----
         8'h31: entry = {3'd5, 6'b011110}; // 1 .----
         8'h32: entry = {3'd5, 6'b001110}; // 2 ..---
         8'h33: entry = {3'd5, 6'b000110}; // 3 ...--
         8'h34: entry = {3'd5, 6'b000010}; // 4 ....-
         8'h35: entry = {3'd5, 6'b000000}; // 5 .....
         8'h36: entry = {3'd5, 6'b100000}; // 6 -....
         8'h37: entry = {3'd5, 6'b110000}; // 7 --...
         8'h38: entry = {3'd5, 6'b111000}; // 8 ---..
         8'h39: entry = {3'd5, 6'b111100}; // 9 ----.
         8'h2E: entry = {3'd6, 6'b010101}; // . .-.-.-
         8'h2C: entry = {3'd6, 6'b110011}; // , --..--
         8'h3F: entry = {3'd6, 6'b001100}; // ? ..--..
         8'h2F: entry = {3'd5, 6'b100100}; // / -..-.
         8'h3D: entry = {3'd5, 6'b100010}; // = -...-
         8'h2D: entry = {3'd6, 6'b100001}; // - -....-
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/morse_tx_engine.sv
// On-off keyed Morse transmitter fed by an ASCII valid/ready byte stream.
// Latency: first tone on morse_out the cycle after accept; in_ready returns the cycle after the last gap cycle.
// Backpressure: in_ready is high only in IDLE; bytes are taken one at a time and held off until the character's gap ends.
//
// Ports: clk_morse, arst_n (async, active-low)
//        in_valid/in_data/in_ready - byte handshake; in_data sampled only at accept
//        morse_out - keyed output, 1 = tone
//        busy      - character or gap in progress
//        err_pulse - one-cycle flag that an unsupported byte was dropped
//        gap_extra - extra gap units added to letter/word gaps (only with MORSE_FARNSWORTH_EN)
// Build option: define MORSE_FARNSWORTH_EN to add the gap_extra port.
module morse_tx_engine
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_TICKS       = 4,
   parameter int unsigned DASH_UNITS       = 3,
   parameter int unsigned LETTER_GAP_UNITS = 3,
   parameter int unsigned WORD_GAP_UNITS   = 7
) (
   input  logic       clk_morse,
   input  logic       arst_n,
`ifdef MORSE_FARNSWORTH_EN
   input  logic [3:0] gap_extra,
`endif
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       morse_out,
   output logic       busy,
   output logic       err_pulse
);

   localparam int unsigned TICK_W = $clog2(UNIT_TICKS + 1);
`ifdef MORSE_FARNSWORTH_EN
   // Parameter gap plus up to 15 extra units needs a fifth bit.
   localparam int unsigned UNIT_CW = 5;
`else
   localparam int unsigned UNIT_CW = 4;
`endif
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(UNIT_TICKS - 1);

   morse_state_t          state_q, state_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [UNIT_CW-1:0]    unit_q, unit_d;
   logic [MORSE_MAX_ELEMS-1:0] pat_q, pat_d;
   logic [2:0]            elem_q, elem_d;
   logic                  err_d;

   morse_entry_t          lut_entry;
   logic                  lut_space;
   logic                  lut_valid;

   logic                  accept;
   logic                  unit_done;
   logic                  last_unit;
   logic [UNIT_CW-1:0]    unit_target;
   logic [UNIT_CW-1:0]    gap_add;

   morse_char_lut u_lut (
      .ascii    (in_data),
      .entry    (lut_entry),
      .is_space (lut_space),
      .valid    (lut_valid)
   );

   assign accept = in_valid & in_ready;

`ifdef MORSE_FARNSWORTH_EN
   logic [3:0] extra_q;

   always_ff @(posedge clk_morse or negedge arst_n) begin
      if (!arst_n) begin
         extra_q <= '0;
      end else if (accept) begin
         extra_q <= gap_extra;
      end
   end

   assign gap_add = UNIT_CW'(extra_q);
`else
   assign gap_add = '0;
`endif

   // Length in units of the state currently being timed.
   always_comb begin
      unit_target = UNIT_CW'(1);
      case (state_q)
         MARK:    unit_target = pat_q[MORSE_MAX_ELEMS-1] ? UNIT_CW'(DASH_UNITS) : UNIT_CW'(1);
         ESPACE:  unit_target = UNIT_CW'(1);
         LGAP:    unit_target = UNIT_CW'(LETTER_GAP_UNITS) + gap_add;
         // The letter gap before a space has already elapsed, so only the remainder is added.
         WGAP:    unit_target = UNIT_CW'(WORD_GAP_UNITS - LETTER_GAP_UNITS) + gap_add;
         default: unit_target = UNIT_CW'(1);
      endcase
   end

   assign unit_done = (tick_q == TICK_LAST);
   assign last_unit = unit_done && (unit_q == unit_target - 1'b1);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      unit_d  = unit_q;
      pat_d   = pat_q;
      elem_d  = elem_q;
      err_d   = 1'b0;

      if (state_q == IDLE) begin
         tick_d = '0;
         unit_d = '0;
         if (accept) begin
            if (!lut_valid) begin
               err_d = 1'b1;
            end else if (lut_space) begin
               state_d = WGAP;
            end else begin
               state_d = MARK;
               pat_d   = lut_entry.pat;
               elem_d  = lut_entry.len;
            end
         end
      end else begin
         if (!unit_done) begin
            tick_d = tick_q + 1'b1;
         end else begin
            tick_d = '0;
            if (!last_unit) begin
               unit_d = unit_q + 1'b1;
            end else begin
               unit_d = '0;
               case (state_q)
                  MARK: begin
                     if (elem_q > 3'd1) begin
                        state_d = ESPACE;
                        pat_d   = pat_q << 1;
                        elem_d  = elem_q - 3'd1;
                     end else begin
                        state_d = LGAP;
                     end
                  end
                  ESPACE:  state_d = MARK;
                  default: state_d = IDLE;
               endcase
            end
         end
      end
   end

   // Outputs are registered from next state so they line up with the state they describe.
   always_ff @(posedge clk_morse or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         unit_q    <= '0;
         pat_q     <= '0;
         elem_q    <= '0;
         in_ready  <= 1'b1;
         morse_out <= 1'b0;
         busy      <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         unit_q    <= unit_d;
         pat_q     <= pat_d;
         elem_q    <= elem_d;
         in_ready  <= (state_d == IDLE);
         morse_out <= (state_d == MARK);
         busy      <= (state_d != IDLE);
         err_pulse <= err_d;
      end
   end

endmodule

// File: tb/tb_morse_tx_engine.sv
// Directed bench for morse_tx_engine with UNIT_TICKS=2 and default gap parameters.
// Each character's morse_out trace is captured cycle by cycle after accept and
// compared with a hand-derived bit string (bit 0 = first cycle after accept).
module tb_morse_tx_engine;

   logic       clk_morse;
   logic       arst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       morse_out;
   logic       busy;
   logic       err_pulse;
`ifdef MORSE_FARNSWORTH_EN
   logic [3:0] gap_extra;
`endif

   int checks;
   int failures;

   morse_tx_engine #(
      .UNIT_TICKS       (2),
      .DASH_UNITS       (3),
      .LETTER_GAP_UNITS (3),
      .WORD_GAP_UNITS   (7)
   ) dut (
      .clk_morse (clk_morse),
      .arst_n    (arst_n),
`ifdef MORSE_FARNSWORTH_EN
      .gap_extra (gap_extra),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .morse_out (morse_out),
      .busy      (busy),
      .err_pulse (err_pulse)
   );

   initial clk_morse = 1'b0;
   always #5 clk_morse = ~clk_morse;

   typedef struct {
      logic [7:0]  ch;
      int          exp_len;
      logic [63:0] exp_tr;
      int          exp_err;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Present one byte for one cycle, then trace the engine until in_ready returns.
   task automatic run_char(input logic [7:0] ch, output int len, output logic [63:0] tr,
                           output int errs, output int mism, output bit to);
      int c;
      @(negedge clk_morse);
      in_valid = 1'b1;
      in_data  = ch;
      @(negedge clk_morse);
      in_valid = 1'b0;
      in_data  = 8'h55;
      len  = 0;
      tr   = '0;
      errs = 0;
      mism = 0;
      to   = 1'b1;
      for (c = 1; c <= 100; c++) begin
         if (err_pulse) errs++;
         if (busy === in_ready) mism++;
         if (in_ready) begin
            to = 1'b0;
            break;
         end
         if (c <= 64) tr[c-1] = morse_out;
         len++;
         @(negedge clk_morse);
      end
   endtask

   initial begin
      int          len, errs, mism;
      logic [63:0] tr;
      bit          to;
      logic [7:0]  stream [3];
      int          idx;
      logic [31:0] mo_tr, rdy_tr;

      checks   = 0;
      failures = 0;
      in_valid = 1'b0;
      in_data  = 8'h00;
`ifdef MORSE_FARNSWORTH_EN
      gap_extra = 4'd0;
`endif

      //            ch     len  trace (bit0 = cycle 1)   err
      vecs[0]  = '{8'h45,   8, 64'h3,                   0}; // E
      vecs[1]  = '{8'h61,  16, 64'h3F3,                 0}; // a
      vecs[2]  = '{8'h41,  16, 64'h3F3,                 0}; // A
      vecs[3]  = '{8'h54,  12, 64'h3F,                  0}; // T
      vecs[4]  = '{8'h49,  12, 64'h33,                  0}; // I
      vecs[5]  = '{8'h4D,  20, 64'h3F3F,                0}; // M
      vecs[6]  = '{8'h35,  24, 64'h33333,               0}; // 5
      vecs[7]  = '{8'h30,  44, 64'h3F3F3F3F3F,          0}; // 0
      vecs[8]  = '{8'h20,   8, 64'h0,                   0}; // space
      vecs[9]  = '{8'h2F,  32, 64'h033F333F,            0}; // /
      vecs[10] = '{8'h3F,  36, 64'h333F3F33,            0}; // ?
      vecs[11] = '{8'h7A,  28, 64'h333F3F,              0}; // z
      vecs[12] = '{8'h7E,   0, 64'h0,                   1}; // ~ unsupported
      vecs[13] = '{8'h40,   0, 64'h0,                   1}; // @ unsupported

      // Reset state
      arst_n = 1'b0;
      #12;
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_morse_out", 64'(morse_out), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_err_pulse", 64'(err_pulse), 64'd0);
      @(negedge clk_morse);
      arst_n = 1'b1;

      // Table-driven characters
      for (int v = 0; v < 14; v++) begin
         run_char(vecs[v].ch, len, tr, errs, mism, to);
         chk($sformatf("timeout[%0d]", v),  64'(to),   64'd0);
         chk($sformatf("busy_len[%0d]", v), 64'(len),  64'(vecs[v].exp_len));
         chk($sformatf("trace[%0d]", v),    tr,        vecs[v].exp_tr);
         chk($sformatf("err[%0d]", v),      64'(errs), 64'(vecs[v].exp_err));
         chk($sformatf("busy_rdy[%0d]", v), 64'(mism), 64'd0);
      end

      // "E E" streamed with in_valid held; junk on in_data while not ready must be ignored.
      stream[0] = 8'h45;
      stream[1] = 8'h20;
      stream[2] = 8'h45;
      idx = 0;
      mo_tr  = '0;
      rdy_tr = '0;
      @(negedge clk_morse);
      in_valid = 1'b1;
      in_data  = stream[0];
      idx = 1;
      for (int c = 1; c <= 27; c++) begin
         @(negedge clk_morse);
         mo_tr[c-1]  = morse_out;
         rdy_tr[c-1] = in_ready;
         if (in_ready && idx < 3) begin
            in_data = stream[idx];
            idx++;
         end else if (in_ready) begin
            in_valid = 1'b0;
         end else begin
            in_data = 8'h7E;
         end
      end
      in_valid = 1'b0;
      chk("stream_morse", 64'(mo_tr),  64'h000C0003);
      chk("stream_ready", 64'(rdy_tr), 64'h04020100);

      // Unsupported byte followed immediately by 'T' in the err_pulse cycle.
      @(negedge clk_morse);
      in_valid = 1'b1;
      in_data  = 8'h7E;
      @(negedge clk_morse);
      chk("err_pulse_hi",  64'(err_pulse), 64'd1);
      chk("err_ready",     64'(in_ready),  64'd1);
      chk("err_busy",      64'(busy),      64'd0);
      chk("err_morse",     64'(morse_out), 64'd0);
      in_data = 8'h54;
      @(negedge clk_morse);
      in_valid = 1'b0;
      chk("err_pulse_lo",  64'(err_pulse), 64'd0);
      chk("after_err_mo",  64'(morse_out), 64'd1);
      chk("after_err_rdy", 64'(in_ready),  64'd0);

      // Reset in the middle of the dash: outputs clear at once, 'T' replays in full.
      @(negedge clk_morse);
      chk("mid_dash_mo", 64'(morse_out), 64'd1);
      #2;
      arst_n = 1'b0;
      #1;
      chk("arst_mo",    64'(morse_out), 64'd0);
      chk("arst_ready", 64'(in_ready),  64'd1);
      chk("arst_busy",  64'(busy),      64'd0);
      @(negedge clk_morse);
      arst_n = 1'b1;
      run_char(8'h54, len, tr, errs, mism, to);
      chk("replay_timeout", 64'(to),  64'd0);
      chk("replay_len",     64'(len), 64'd12);
      chk("replay_trace",   tr,       64'h3F);

`ifdef MORSE_FARNSWORTH_EN
      gap_extra = 4'd2;
      run_char(8'h45, len, tr, errs, mism, to);
      chk("farns_timeout", 64'(to),  64'd0);
      chk("farns_len",     64'(len), 64'd12);
      chk("farns_trace",   tr,       64'h3);
      gap_extra = 4'd0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
